// File: rtl/misr_compactor.sv
// misr_compactor: 8-bit Galois MISR that compacts NPAT response vectors per session
// and flags whether the final signature matches GOLDEN. Three-state control FSM
// (idle / run / done); every output is driven straight from a register.

module misr_compactor #(
  parameter logic [7:0]  SEED   = 8'h00,
  parameter logic [15:0] NPAT   = 16'd255,
  parameter logic [7:0]  GOLDEN = 8'h00
) (
  input  logic        clk,
  input  logic        set,
  input  logic        start,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  sig,
  output logic [15:0] count
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  sig_q, sig_d;
  logic [15:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [7:0]  misr_nxt;
  logic        last_vec;

  // Galois MISR step for x^8+x^4+x^3+x^2+1: sig[7] feeds back into taps 0, 2, 3 and 4.
  always_comb begin
    misr_nxt[0] = sig_q[7] ^ din[0];
    misr_nxt[1] = sig_q[0] ^ din[1];
    misr_nxt[2] = sig_q[1] ^ sig_q[7] ^ din[2];
    misr_nxt[3] = sig_q[2] ^ sig_q[7] ^ din[3];
    misr_nxt[4] = sig_q[3] ^ sig_q[7] ^ din[4];
    misr_nxt[5] = sig_q[4] ^ din[5];
    misr_nxt[6] = sig_q[5] ^ din[6];
    misr_nxt[7] = sig_q[6] ^ din[7];
  end

  // The vector accepted while count sits at NPAT-1 is the last one of the session,
  // so count can never step past NPAT.
  assign last_vec = (count_q == (NPAT - 16'd1));

  // Next-state and registered-output logic; everything holds unless a case changes it.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      // Idle and done share the restart path; din_valid is ignored in both, and start
      // takes priority so a coincident vector is never compacted.
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          sig_d   = SEED;
          count_d = 16'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      // start is deliberately not looked at here: a running session cannot be restarted.
      StRun: begin
        if (din_valid) begin
          sig_d   = misr_nxt;
          count_d = count_q + 16'd1;
          if (last_vec) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_nxt == GOLDEN);
          end
        end
      end

      default: begin
        state_d = StIdle;
        sig_d   = SEED;
        count_d = 16'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; set low clears the session immediately, no clock needed.
  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      count_q <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;
  assign sig   = sig_q;
  assign count = count_q;

  // Invariants tying the registered flags to the FSM state.
  a_busy_is_run: assert property (@(posedge clk) disable iff (!set)
    busy_q == (state_q == StRun));
  a_done_is_done: assert property (@(posedge clk) disable iff (!set)
    done_q == (state_q == StDone));
  a_pass_needs_done: assert property (@(posedge clk) disable iff (!set)
    !done_q |-> !pass_q);
  a_count_bounded: assert property (@(posedge clk) disable iff (!set)
    count_q <= NPAT);

endmodule

// File: tb/tb_misr_compactor.sv
// Scoreboard bench for misr_compactor. Four instances with different parameter sets
// share clk and set; stimulus pushes the expected end-of-session result, and a monitor
// pops and compares it whenever an instance raises done.

module tb_misr_compactor;

  typedef struct {
    int          id;
    logic [7:0]  sig;
    logic [15:0] cnt;
    logic        pass;
  } exp_t;

  logic        clk;
  logic        set;
  logic [3:0]  start_v;
  logic [3:0]  dv_v;
  logic [7:0]  din_v [4];
  logic [3:0]  busy_w;
  logic [3:0]  done_w;
  logic [3:0]  pass_w;
  logic [7:0]  sig_w [4];
  logic [15:0] count_w [4];

  exp_t sb[$];
  int   checks;
  int   errors;
  logic [3:0] done_prev;

  // 0: two-vector pass case, 1: feedback case, 2: two-vector fail case, 3: abort case
  misr_compactor #(.SEED(8'h00), .NPAT(16'd2), .GOLDEN(8'h02)) u_a (
    .clk(clk), .set(set), .start(start_v[0]), .din_valid(dv_v[0]), .din(din_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .sig(sig_w[0]), .count(count_w[0])
  );
  misr_compactor #(.SEED(8'h80), .NPAT(16'd1), .GOLDEN(8'h1D)) u_b (
    .clk(clk), .set(set), .start(start_v[1]), .din_valid(dv_v[1]), .din(din_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .sig(sig_w[1]), .count(count_w[1])
  );
  misr_compactor #(.SEED(8'h00), .NPAT(16'd2), .GOLDEN(8'h03)) u_c (
    .clk(clk), .set(set), .start(start_v[2]), .din_valid(dv_v[2]), .din(din_v[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .sig(sig_w[2]), .count(count_w[2])
  );
  misr_compactor #(.SEED(8'h00), .NPAT(16'd5), .GOLDEN(8'h8E)) u_d (
    .clk(clk), .set(set), .start(start_v[3]), .din_valid(dv_v[3]), .din(din_v[3]),
    .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .sig(sig_w[3]), .count(count_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input int id, input string name, input logic [7:0] s,
                           input logic [15:0] c, input logic b, input logic d,
                           input logic p);
    chk({name, ".sig"},   {24'd0, sig_w[id]},   {24'd0, s});
    chk({name, ".count"}, {16'd0, count_w[id]}, {16'd0, c});
    chk({name, ".flags"}, {29'd0, busy_w[id], done_w[id], pass_w[id]}, {29'd0, b, d, p});
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int id);
    start_v[id] = 1'b1;
    cycle(1);
    start_v[id] = 1'b0;
  endtask

  task automatic send(input int id, input logic [7:0] d);
    dv_v[id]  = 1'b1;
    din_v[id] = d;
    cycle(1);
    dv_v[id]  = 1'b0;
    din_v[id] = 8'h00;
  endtask

  task automatic push(input int id, input logic [7:0] s, input logic [15:0] c, input logic p);
    exp_t e;
    e.id = id; e.sig = s; e.cnt = c; e.pass = p;
    sb.push_back(e);
  endtask

  // Monitor: on each done rising edge pop the oldest expectation and compare;
  // also enforce pass=0 whenever done=0.
  initial done_prev = 4'b0000;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_w[i] === 1'b1 && done_prev[i] === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: instance %0d raised done, scoreboard empty", i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb.id",    i,                       e.id);
          chk("sb.sig",   {24'd0, sig_w[i]},       {24'd0, e.sig});
          chk("sb.count", {16'd0, count_w[i]},     {16'd0, e.cnt});
          chk("sb.pass",  {31'd0, pass_w[i]},      {31'd0, e.pass});
          chk("sb.busy",  {31'd0, busy_w[i]},      32'd0);
        end
      end
      if (done_w[i] === 1'b0 && pass_w[i] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pass_without_done: instance %0d pass=%b", i, pass_w[i]);
      end
      done_prev[i] = done_w[i];
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    set     = 1'b1;
    start_v = 4'b0000;
    dv_v    = 4'b0000;
    for (int i = 0; i < 4; i++) din_v[i] = 8'h00;

    // Reset applied mid-cycle must take effect with no clock edge.
    @(posedge clk);
    #3;
    set = 1'b0;
    #1;
    chk_state(0, "reset_a", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    chk_state(1, "reset_b", 8'h80, 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    set = 1'b1;
    cycle(1);

    // din_valid in idle is ignored.
    send(0, 8'hFF);
    chk_state(0, "idle_ignore", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);

    // start together with din_valid: only start acts.
    start_v[0] = 1'b1;
    dv_v[0]    = 1'b1;
    din_v[0]   = 8'hFF;
    cycle(1);
    start_v[0] = 1'b0;
    dv_v[0]    = 1'b0;
    chk_state(0, "start_with_dv", 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    push(0, 8'h02, 16'd2, 1'b1);
    cycle(1);
    pulse_start(0);
    chk_state(0, "start_in_run", 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    send(0, 8'h01);
    chk_state(0, "vec1", 8'h01, 16'd1, 1'b1, 1'b0, 1'b0);
    cycle(2);
    chk_state(0, "gap_hold", 8'h01, 16'd1, 1'b1, 1'b0, 1'b0);
    send(0, 8'h00);
    chk_state(0, "vec2", 8'h02, 16'd2, 1'b0, 1'b1, 1'b1);

    // din_valid in done is ignored; state holds.
    send(0, 8'h55);
    cycle(1);
    chk_state(0, "done_ignore", 8'h02, 16'd2, 1'b0, 1'b1, 1'b1);

    // Restart from done, then a full second session.
    pulse_start(0);
    chk_state(0, "restart", 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    push(0, 8'h02, 16'd2, 1'b1);
    send(0, 8'h01);
    cycle(1);
    send(0, 8'h00);
    cycle(1);

    // Feedback path: SEED 80, one zero vector gives 1D.
    pulse_start(1);
    chk_state(1, "fb_start", 8'h80, 16'd0, 1'b1, 1'b0, 1'b0);
    push(1, 8'h1D, 16'd1, 1'b1);
    send(1, 8'h00);
    cycle(1);

    // Same two-vector session against the wrong golden value.
    pulse_start(2);
    push(2, 8'h02, 16'd2, 1'b0);
    send(2, 8'h01);
    send(2, 8'h00);
    cycle(1);
    chk_state(2, "fail_case", 8'h02, 16'd2, 1'b0, 1'b1, 1'b0);

    // Abort after 3 of 5 vectors.
    pulse_start(3);
    send(3, 8'hA5);
    send(3, 8'h3C);
    send(3, 8'h00);
    chk_state(3, "partial", 8'hD6, 16'd3, 1'b1, 1'b0, 1'b0);
    #2;
    set = 1'b0;
    #1;
    chk_state(3, "abort", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    chk_state(0, "abort_a", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    // Release between edges with start already high: the next edge must honour it.
    @(negedge clk);
    set        = 1'b1;
    start_v[3] = 1'b1;
    #1;
    chk_state(3, "released", 8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start_v[3] = 1'b0;
    chk_state(3, "start_after_rel", 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    push(3, 8'h8E, 16'd5, 1'b1);
    send(3, 8'hA5);
    send(3, 8'h3C);
    cycle(1);
    send(3, 8'h00);
    send(3, 8'hFF);
    send(3, 8'h12);
    cycle(3);
    chk_state(3, "done_hold", 8'h8E, 16'd5, 1'b0, 1'b1, 1'b1);

    // Any expectation still queued means its done never arrived.
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_done: instance %0d never finished, expected sig %0h", e.id, e.sig);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
